ldpc_iter_scheduler: RTL and testbench
======================================

# ldpc_iter_scheduler

Top-level sequencing controller for the LDPC QKD decoder datapath. On each start request it loads one frame of channel LLRs and runs layered check-node (CN) and variable-node (VN) sweeps, one iteration at a time. After every iteration it tests the parity syndrome, stops early on convergence or after `max_iter` iterations, and streams the decoded frame out. It drives the address/enable strobes for the LLR memory, CN/VN units and output buffer, and replaces free-running iteration counting with a bounded, restartable schedule.

## Interface
Parameters:
- `log2n`, 4, width of column/address counters
- `n`, 12, variable nodes (LLR words) per frame
- `log2m`, 2, width of layer index
- `m`, 3, number of check-node layers
- `log2i`, 4, width of iteration counter; must hold `max_iter-1`
- `max_iter`, 10, maximum decoding iterations (≥1)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: frame-start request; sampled only in IDLE
- `syndrome_ok` in 1: all parity checks satisfied; sampled only in CHECK
- `busy` out 1: high in every state except IDLE
- `load_en` out 1: LLR write strobe (LOAD)
- `load_addr` out log2n: LLR write address
- `cn_en` out 1: CN update strobe (CN)
- `vn_en` out 1: VN update strobe (VN)
- `layer_idx` out log2m: current CN layer
- `col_addr` out log2n: current column in CN/VN sweeps
- `out_en` out 1: hard-decision read strobe (OUTPUT)
- `out_addr` out log2n: output read address
- `iter_count` out log2i: zero-based index of current/last iteration
- `converged` out 1: last frame ended with `syndrome_ok`=1
- `done` out 1: one-cycle end-of-frame pulse
- `state` out 3: FSM state encoding

## Operation
- States and `state` encoding: IDLE=0, LOAD=1, CN=2, VN=3, CHECK=4, OUTPUT=5, DONE=6; 7 is unused and must return to IDLE on the next cycle.
- IDLE: `start`=1 → LOAD. On entry to LOAD, clear `iter_count`, `converged`, column counter and layer counter.
- LOAD: `load_en`=1 and `load_addr`=0..n-1 over n cycles → CN.
- CN: `cn_en`=1. `col_addr` sweeps 0..n-1 once per layer for `layer_idx`=0..m-1, giving m·n cycles. `col_addr` wraps to 0 and `layer_idx` increments on each column wrap → VN, with `layer_idx` and `col_addr` reset to 0.
- VN: `vn_en`=1 and `col_addr` sweeps 0..n-1 over n cycles → CHECK.
- CHECK: lasts one cycle; all strobes are low.
  - `syndrome_ok`=1 → OUTPUT, `converged`←1.
  - Otherwise, if `iter_count`==max_iter-1 → OUTPUT, `converged`←0.
  - Otherwise `iter_count`←`iter_count`+1 → CN.
- OUTPUT: `out_en`=1 and `out_addr`=0..n-1 over n cycles → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `iter_count` and `converged` hold their values in IDLE until the next accepted `start`.
- `start` outside IDLE is ignored, including in DONE. No queuing.
- Address outputs are 0 whenever their strobe is low.
- Counters compare against `n-1`/`m-1` exactly. No arithmetic overflow is possible when `log2*` are sized per the parameters.

## Timing
- Every output is registered or decoded from registered state only. There is no combinational input→output path.
- Reset: state=IDLE (0). `busy`, all strobes, all addresses, `layer_idx`, `iter_count`, `converged` and `done` are 0 in the cycle after `rst` is sampled high. A reset during any state aborts the frame with no `done`.
- Start latency: `start` sampled in cycle T → `load_en`=1 with `load_addr`=0 in T+1.
- One iteration costs m·n+n+1 cycles (CN+VN+CHECK). A frame of k iterations has `done` at T + n + k(m·n+n+1) + n + 1.
- Defaults, k=1: LOAD T+1..T+12, CN T+13..T+48, VN T+49..T+60, CHECK T+61, OUTPUT T+62..T+73, `done` at T+74.
- The earliest next `start` is accepted in T+75, when the FSM is in IDLE.

## Test plan
- Reset then idle: hold `rst` 2 cycles, then `start`=0 for 20 cycles → all outputs 0, `state`=0 throughout.
- Early convergence, defaults: pulse `start` at T, `syndrome_ok`=1 → 12 `load_en` cycles (addr 0..11), 36 `cn_en` cycles (layers 0,1,2 × cols 0..11), 12 `vn_en`, 12 `out_en`. Expect `done` exactly at T+74, `converged`=1, `iter_count`=0.
- Non-convergence: `syndrome_ok`=0 always → 10 CHECK visits, `iter_count` 0..9, `done` at T+515, `converged`=0, `iter_count` held at 9 in IDLE.
- Convergence on iteration 3: raise `syndrome_ok` only in the third CHECK → `done` at T+172, `converged`=1, `iter_count`=2.
- Ignored start: pulse `start` during CN and during DONE → no restart, no change to schedule. The next `start` in IDLE clears `iter_count` and `converged` in the following cycle.
- Reset mid-frame: assert `rst` in VN of iteration 2 → next cycle IDLE with all outputs 0 and no `done`. A subsequent `start` runs a full, correct frame.

Source files
------------

// File: rtl/ldpc_iter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_iter_scheduler
// Description : Frame sequencer for the LDPC decoder (load, layered CN/VN
//               sweeps, syndrome check with early exit, output streaming).
// Revision    : 1.0 - initial release
// ============================================================================
module ldpc_iter_scheduler #(
   parameter int log2n    = 4,
   parameter int n        = 12,
   parameter int log2m    = 2,
   parameter int m        = 3,
   parameter int log2i    = 4,
   parameter int max_iter = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             syndrome_ok,
   output logic             busy,
   output logic             load_en,
   output logic [log2n-1:0] load_addr,
   output logic             cn_en,
   output logic             vn_en,
   output logic [log2m-1:0] layer_idx,
   output logic [log2n-1:0] col_addr,
   output logic             out_en,
   output logic [log2n-1:0] out_addr,
   output logic [log2i-1:0] iter_count,
   output logic             converged,
   output logic             done,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CN     = 3'd2,
      S_VN     = 3'd3,
      S_CHECK  = 3'd4,
      S_OUTPUT = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [log2n-1:0] c_last_col   = log2n'(n - 1);
   localparam logic [log2m-1:0] c_last_layer = log2m'(m - 1);
   localparam logic [log2i-1:0] c_last_iter  = log2i'(max_iter - 1);

   state_t cur;

   assign state = cur;

   // Address registers double as the sweep counters; each is returned to 0
   // on leaving its state so addresses read 0 whenever their strobe is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur        <= S_IDLE;
         busy       <= 1'b0;
         load_en    <= 1'b0;
         load_addr  <= '0;
         cn_en      <= 1'b0;
         vn_en      <= 1'b0;
         layer_idx  <= '0;
         col_addr   <= '0;
         out_en     <= 1'b0;
         out_addr   <= '0;
         iter_count <= '0;
         converged  <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (cur)
            S_IDLE: begin
               if (start) begin
                  cur        <= S_LOAD;
                  busy       <= 1'b1;
                  load_en    <= 1'b1;
                  load_addr  <= '0;
                  col_addr   <= '0;
                  layer_idx  <= '0;
                  iter_count <= '0;
                  converged  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (load_addr == c_last_col) begin
                  cur       <= S_CN;
                  load_en   <= 1'b0;
                  load_addr <= '0;
                  cn_en     <= 1'b1;
               end else begin
                  load_addr <= load_addr + 1'b1;
               end
            end
            S_CN: begin
               if (col_addr == c_last_col) begin
                  col_addr <= '0;
                  if (layer_idx == c_last_layer) begin
                     cur       <= S_VN;
                     layer_idx <= '0;
                     cn_en     <= 1'b0;
                     vn_en     <= 1'b1;
                  end else begin
                     layer_idx <= layer_idx + 1'b1;
                  end
               end else begin
                  col_addr <= col_addr + 1'b1;
               end
            end
            S_VN: begin
               if (col_addr == c_last_col) begin
                  cur      <= S_CHECK;
                  col_addr <= '0;
                  vn_en    <= 1'b0;
               end else begin
                  col_addr <= col_addr + 1'b1;
               end
            end
            S_CHECK: begin
               if (syndrome_ok) begin
                  cur       <= S_OUTPUT;
                  converged <= 1'b1;
                  out_en    <= 1'b1;
                  out_addr  <= '0;
               end else if (iter_count == c_last_iter) begin
                  cur       <= S_OUTPUT;
                  converged <= 1'b0;
                  out_en    <= 1'b1;
                  out_addr  <= '0;
               end else begin
                  cur        <= S_CN;
                  iter_count <= iter_count + 1'b1;
                  cn_en      <= 1'b1;
               end
            end
            S_OUTPUT: begin
               if (out_addr == c_last_col) begin
                  cur      <= S_DONE;
                  out_en   <= 1'b0;
                  out_addr <= '0;
                  done     <= 1'b1;
               end else begin
                  out_addr <= out_addr + 1'b1;
               end
            end
            S_DONE: begin
               cur  <= S_IDLE;
               busy <= 1'b0;
               done <= 1'b0;
            end
            default: begin
               // Unused encoding: fall back to a quiet IDLE.
               cur       <= S_IDLE;
               busy      <= 1'b0;
               load_en   <= 1'b0;
               load_addr <= '0;
               cn_en     <= 1'b0;
               vn_en     <= 1'b0;
               layer_idx <= '0;
               col_addr  <= '0;
               out_en    <= 1'b0;
               out_addr  <= '0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ldpc_iter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldpc_iter_scheduler
// Description : Directed bench for ldpc_iter_scheduler, cycle-exact schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldpc_iter_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       syndrome_ok = 1'b0;
   logic       busy, load_en, cn_en, vn_en, out_en, converged, done;
   logic [3:0] load_addr, col_addr, out_addr, iter_count;
   logic [1:0] layer_idx;
   logic [2:0] state;
   logic [27:0] obs;

   int pass_cnt = 0;
   int total_cnt = 0;

   ldpc_iter_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .syndrome_ok(syndrome_ok),
      .busy(busy), .load_en(load_en), .load_addr(load_addr),
      .cn_en(cn_en), .vn_en(vn_en), .layer_idx(layer_idx),
      .col_addr(col_addr), .out_en(out_en), .out_addr(out_addr),
      .iter_count(iter_count), .converged(converged), .done(done),
      .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {busy, load_en, load_addr, cn_en, vn_en, layer_idx, col_addr,
                 out_en, out_addr, iter_count, converged, done, state};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Expected output vector t cycles after start was sampled, for a frame of
   // k iterations (12 LOAD, k x (36 CN + 12 VN + 1 CHECK), 12 OUTPUT, DONE).
   function automatic logic [27:0] model(int t, int k, bit conv);
      int st = 0, la = 0, ly = 0, ca = 0, oa = 0, it = 0, cv = 0;
      int i, off, o;
      if (t <= 12) begin
         st = 1; la = t - 1;
      end else begin
         i   = (t - 13) / 49;
         off = (t - 13) % 49;
         if (i < k) begin
            it = i;
            if (off < 36) begin st = 2; ly = off / 12; ca = off % 12; end
            else if (off < 48) begin st = 3; ca = off - 36; end
            else st = 4;
         end else begin
            o  = t - 13 - k * 49;
            it = k - 1;
            cv = conv;
            if (o < 12) begin st = 5; oa = o; end
            else if (o == 12) st = 6;
            else st = 0;
         end
      end
      return {st != 0, st == 1, la[3:0], st == 2, st == 3, ly[1:0], ca[3:0],
              st == 5, oa[3:0], it[3:0], cv[0], st == 6, st[2:0]};
   endfunction

   function automatic bit in_check(int t, int k, int iter);
      return (t >= 13) && ((t - 13) / 49 == iter) && (iter < k) && ((t - 13) % 49 == 48);
   endfunction

   // conv_at: iteration index whose CHECK sees syndrome_ok (-1: never).
   task automatic run_frame(input int id, input int conv_at, input bit syn_always,
                            input bit stray_starts, input int abort_t);
      int  k, done_t, t_end, dones;
      bit  conv;
      logic [27:0] exp;
      k      = (conv_at >= 0) ? conv_at + 1 : 10;
      conv   = (conv_at >= 0);
      done_t = 12 + k * 49 + 13;
      t_end  = (abort_t > 0) ? abort_t + 6 : done_t + 2;
      dones  = 0;
      check($sformatf("f%0d pre-start idle", id), {29'd0, state}, 32'd0);
      start = 1'b1;
      syndrome_ok = syn_always;
      @(negedge clk);
      start = 1'b0;
      for (int t = 1; t <= t_end; t++) begin
         exp = (abort_t > 0 && t > abort_t) ? 28'd0 : model(t, k, conv);
         check($sformatf("f%0d t%0d vec", id, t), {4'd0, obs}, {4'd0, exp});
         if (done) dones++;
         rst = (abort_t > 0 && t == abort_t);
         start = stray_starts && (t == 20 || t == done_t);
         syndrome_ok = syn_always || (conv_at >= 0 && in_check(t, k, conv_at));
         @(negedge clk);
      end
      start = 1'b0;
      syndrome_ok = 1'b0;
      check($sformatf("f%0d done pulses", id), dones, (abort_t > 0) ? 0 : 1);
      if (abort_t == 0) begin
         check($sformatf("f%0d held iter_count", id), {28'd0, iter_count}, k - 1);
         check($sformatf("f%0d held converged", id), {31'd0, converged}, {31'd0, conv});
      end
   endtask

   initial begin
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         check($sformatf("idle c%0d", c), {4'd0, obs}, 32'd0);
         @(negedge clk);
      end
      // early convergence, syndrome_ok held high
      run_frame(1, 0, 1'b1, 1'b0, 0);
      // never converges: 10 iterations
      run_frame(2, -1, 1'b0, 1'b0, 0);
      // converges in third CHECK, with stray starts in CN and DONE
      run_frame(3, 2, 1'b0, 1'b1, 0);
      // fresh frame clears iter_count/converged from previous frame
      run_frame(4, 0, 1'b0, 1'b0, 0);
      // reset in VN of iteration 2
      run_frame(5, -1, 1'b0, 1'b0, 13 + 49 + 36 + 5);
      // full frame after the abort
      run_frame(6, 1, 1'b0, 1'b0, 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
